transfer_control_register_bank: RTL and testbench
=================================================

TRANSFER_CONTROL_REGISTER_BANK -- requirements
Module: transfer_control_register_bank

Interface
REQ-001 Parameter NUM_REGS, default 4: number of control registers, 1..16.
REQ-002 Parameter REG_BYTES, default 2: bytes per register, 1..4.
REQ-003 Parameters HDR_BYTE1/HDR_BYTE2/HDR_BYTE3, defaults 8'h5A/8'hC3/8'h7E: frame header sequence.
REQ-004 CLK  input  1  sole clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 TRANSFER_IN_RECEIVED  input  1  byte-valid level; a byte is accepted on its rising edge only.
REQ-007 TRANSFER_IN_BYTE  input  8  byte data, stable while TRANSFER_IN_RECEIVED high.
REQ-008 CONTROL_REGISTERS  output  NUM_REGS*REG_BYTES*8  flattened register bank, register i at bits [(i+1)*REG_BYTES*8-1 : i*REG_BYTES*8].
REQ-009 REG_UPDATED  output  NUM_REGS  one-cycle pulse per register committed.
REQ-010 FRAME_ERROR  output  1  one-cycle pulse on rejected frame.

Function
REQ-011 Byte accepted at the edge where TRANSFER_IN_RECEIVED=1 and its registered copy=0; further bytes need RECEIVED low for at least one cycle.
REQ-012 States: IDLE, HDR1, HDR2, ADDR, DATA (plus CHECK when REQ-023 macro defined); state changes only on accepted bytes.
REQ-013 IDLE: HDR_BYTE1 -> HDR1, else stay.
REQ-014 HDR1: HDR_BYTE2 -> HDR2; HDR2: HDR_BYTE3 -> ADDR; on mismatch go HDR1 if byte equals HDR_BYTE1, else IDLE (resync, no FRAME_ERROR).
REQ-015 ADDR: byte < NUM_REGS -> latch address, clear byte counter, go DATA; otherwise pulse FRAME_ERROR, go IDLE.
REQ-016 DATA: bytes shifted MSB-first into staging register; counter width clog2(REG_BYTES)+1; after REG_BYTES-th byte go CHECK (macro) or commit and go IDLE.
REQ-017 Commit: staging value written to addressed register at the accepting edge; visible and REG_UPDATED[addr] high in the following cycle only; other registers unchanged.
REQ-018 FRAME_ERROR and REG_UPDATED default 0; never asserted together.
REQ-019 Header bytes inside DATA are data, not resync.

Reset
REQ-020 RST high at an edge: state IDLE, counter 0, staging 0, all CONTROL_REGISTERS 0, REG_UPDATED 0, FRAME_ERROR 0, edge register 0.
REQ-021 RST overrides a simultaneous accepted byte; a partial frame is discarded with no commit.
REQ-022 After RST release, a RECEIVED already high is accepted at the first edge (edge register cleared).

Configuration
REQ-023 Macro TRANSFER_CTRL_CHECKSUM_EN defined: after the data bytes one checksum byte equal to XOR of address byte and all data bytes; match -> commit per REQ-017, mismatch -> FRAME_ERROR, no commit; both then IDLE.
REQ-024 Macro undefined: no CHECK state, no checksum logic; commit after last data byte.

Structure
REQ-025 Package transfer_ctrl_pkg holds state encoding constants and default header byte constants.
REQ-026 Sub-module transfer_in_edge_detect produces the single-cycle byte-accept strobe from TRANSFER_IN_RECEIVED.

Verification
REQ-027 Frame 5A C3 7E 02 12 34 (defaults, no macro) -> register 2 = 16'h1234, REG_UPDATED=4'b0100 for one cycle, others 0.
REQ-028 Frame 5A C3 7E 04 AA BB -> FRAME_ERROR one pulse after 04, bank unchanged, AA BB ignored.
REQ-029 Bytes 5A 5A C3 7E 01 00 FF -> resync, register 1 = 16'h00FF.
REQ-030 RST asserted after 5A C3 7E 00 12 -> all registers 0, next full frame 5A C3 7E 00 56 78 commits 16'h5678.
REQ-031 Macro defined: 5A C3 7E 01 12 34 27 -> commit 16'h1234; checksum 26 instead -> FRAME_ERROR, register 1 unchanged.
REQ-032 RECEIVED held high for 10 cycles with byte 5A then low -> exactly one byte accepted.

Source files
------------

// File: rtl/transfer_ctrl_pkg.sv
// Shared constants for the transfer control register bank: FSM state encoding
// and default frame header bytes. The CHECK state exists only when
// TRANSFER_CTRL_CHECKSUM_EN is defined.
package transfer_ctrl_pkg;

  localparam logic [7:0] HDR_BYTE1_DEFAULT = 8'h5A;
  localparam logic [7:0] HDR_BYTE2_DEFAULT = 8'hC3;
  localparam logic [7:0] HDR_BYTE3_DEFAULT = 8'h7E;

`ifdef TRANSFER_CTRL_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StHdr1  = 3'd1,
    StHdr2  = 3'd2,
    StAddr  = 3'd3,
    StData  = 3'd4,
    StCheck = 3'd5
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHdr1 = 3'd1,
    StHdr2 = 3'd2,
    StAddr = 3'd3,
    StData = 3'd4
  } state_e;
`endif

endpackage

// File: rtl/transfer_in_edge_detect.sv
// Turns the byte-valid level into a single-cycle accept strobe on its rising
// edge. The registered copy clears on reset, so a level already high when
// reset releases is accepted at the first edge.
module transfer_in_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic received_i,
  output logic accept_o
);

  logic received_q, received_d;

  // Next value of the delayed copy is simply the current level.
  always_comb begin
    received_d = received_i;
  end

  // Delayed copy of the byte-valid level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      received_q <= 1'b0;
    end else begin
      received_q <= received_d;
    end
  end

  assign accept_o = received_i & ~received_q;

endmodule

// File: rtl/transfer_control_register_bank.sv
// Byte-stream frame decoder writing a bank of control registers.
// Frame: HDR1 HDR2 HDR3 ADDR DATA[REG_BYTES] (MSB first).
// Optional macro TRANSFER_CTRL_CHECKSUM_EN appends a checksum byte equal to the
// XOR of the address and data bytes; a mismatch rejects the frame.
module transfer_control_register_bank
  import transfer_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned REG_BYTES = 2,
  parameter logic [7:0]  HDR_BYTE1 = HDR_BYTE1_DEFAULT,
  parameter logic [7:0]  HDR_BYTE2 = HDR_BYTE2_DEFAULT,
  parameter logic [7:0]  HDR_BYTE3 = HDR_BYTE3_DEFAULT
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              TRANSFER_IN_RECEIVED,
  input  logic [7:0]                        TRANSFER_IN_BYTE,
  output logic [NUM_REGS*REG_BYTES*8-1:0]   CONTROL_REGISTERS,
  output logic [NUM_REGS-1:0]               REG_UPDATED,
  output logic                              FRAME_ERROR
);

  localparam int unsigned RegW  = REG_BYTES * 8;
  localparam int unsigned CntW  = $clog2(REG_BYTES) + 1;
  localparam int unsigned AddrW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                accept;
  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic [RegW-1:0]     staging_q, staging_d;
  logic [RegW-1:0]     regs_q [NUM_REGS];
  logic [RegW-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] reg_updated_q, reg_updated_d;
  logic                frame_error_q, frame_error_d;
  logic [RegW-1:0]     shifted;
  logic                commit_en;
  logic [RegW-1:0]     commit_val;
`ifdef TRANSFER_CTRL_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  transfer_in_edge_detect u_edge (
    .clk_i      (CLK),
    .rst_i      (RST),
    .received_i (TRANSFER_IN_RECEIVED),
    .accept_o   (accept)
  );

  // Frame FSM next-state, staging shift and commit decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    staging_d     = staging_q;
    regs_d        = regs_q;
    reg_updated_d = '0;
    frame_error_d = 1'b0;
    commit_en     = 1'b0;
    commit_val    = '0;
    shifted       = RegW'({staging_q, TRANSFER_IN_BYTE});
`ifdef TRANSFER_CTRL_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          if (TRANSFER_IN_BYTE == HDR_BYTE1) state_d = StHdr1;
        end
        StHdr1: begin
          if (TRANSFER_IN_BYTE == HDR_BYTE2)      state_d = StHdr2;
          else if (TRANSFER_IN_BYTE == HDR_BYTE1) state_d = StHdr1;
          else                                    state_d = StIdle;
        end
        StHdr2: begin
          if (TRANSFER_IN_BYTE == HDR_BYTE3)      state_d = StAddr;
          else if (TRANSFER_IN_BYTE == HDR_BYTE1) state_d = StHdr1;
          else                                    state_d = StIdle;
        end
        StAddr: begin
          if ({24'd0, TRANSFER_IN_BYTE} < NUM_REGS) begin
            addr_d  = TRANSFER_IN_BYTE[AddrW-1:0];
            cnt_d   = '0;
            state_d = StData;
`ifdef TRANSFER_CTRL_CHECKSUM_EN
            csum_d  = TRANSFER_IN_BYTE;
`endif
          end else begin
            frame_error_d = 1'b1;
            state_d       = StIdle;
          end
        end
        StData: begin
          // Header values here are plain data; no resync inside the payload.
          staging_d = shifted;
          cnt_d     = cnt_q + 1'b1;
`ifdef TRANSFER_CTRL_CHECKSUM_EN
          csum_d    = csum_q ^ TRANSFER_IN_BYTE;
`endif
          if (cnt_q == CntW'(REG_BYTES - 1)) begin
`ifdef TRANSFER_CTRL_CHECKSUM_EN
            state_d    = StCheck;
`else
            commit_en  = 1'b1;
            commit_val = shifted;
            state_d    = StIdle;
`endif
          end
        end
`ifdef TRANSFER_CTRL_CHECKSUM_EN
        StCheck: begin
          if (TRANSFER_IN_BYTE == csum_q) begin
            commit_en  = 1'b1;
            commit_val = staging_q;
          end else begin
            frame_error_d = 1'b1;
          end
          state_d = StIdle;
        end
`endif
        default: state_d = StIdle;
      endcase
    end

    if (commit_en) begin
      regs_d[addr_q]        = commit_val;
      reg_updated_d[addr_q] = 1'b1;
    end
  end

  // State and register bank; reset wins over a simultaneous accepted byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      staging_q     <= '0;
      reg_updated_q <= '0;
      frame_error_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef TRANSFER_CTRL_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      staging_q     <= staging_d;
      reg_updated_q <= reg_updated_d;
      frame_error_q <= frame_error_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
`ifdef TRANSFER_CTRL_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Flatten the bank onto the output bus, register 0 in the low bits.
  always_comb begin
    CONTROL_REGISTERS = '0;
    for (int i = 0; i < NUM_REGS; i++) CONTROL_REGISTERS[i*RegW +: RegW] = regs_q[i];
  end

  assign REG_UPDATED = reg_updated_q;
  assign FRAME_ERROR = frame_error_q;

endmodule

// File: tb/tb_transfer_control_register_bank.sv
// Directed bench for transfer_control_register_bank with default parameters.
// Checksum scenarios are compiled in when TRANSFER_CTRL_CHECKSUM_EN is defined.
module tb_transfer_control_register_bank;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        recv = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic [63:0] cregs;
  logic [3:0]  upd;
  logic        ferr;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  transfer_control_register_bank dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .TRANSFER_IN_RECEIVED (recv),
    .TRANSFER_IN_BYTE     (byte_in),
    .CONTROL_REGISTERS    (cregs),
    .REG_UPDATED          (upd),
    .FRAME_ERROR          (ferr)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (!RST && ferr === 1'b1 && upd !== 4'b0000) overlap++;
  end

  // One byte: valid high for one cycle, then low; returns just after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    byte_in = b;
    recv    = 1'b1;
    @(negedge CLK);
    recv    = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] hi, input logic [7:0] lo);
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h7E);
    send_byte(a);
    send_byte(hi);
    send_byte(lo);
`ifdef TRANSFER_CTRL_CHECKSUM_EN
    send_byte(a ^ hi ^ lo);
`endif
  endtask

  task automatic test_reset();
    RST  = 1'b1;
    recv = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if (cregs !== 64'h0) begin
      n_fail++; $display("FAIL reset_bank: got %h expected %h", cregs, 64'h0);
    end
    n_checks++;
    if (upd !== 4'b0000) begin
      n_fail++; $display("FAIL reset_upd: got %b expected %b", upd, 4'b0000);
    end
    n_checks++;
    if (ferr !== 1'b0) begin
      n_fail++; $display("FAIL reset_ferr: got %b expected %b", ferr, 1'b0);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_commit();
    send_frame(8'h02, 8'h12, 8'h34);
    n_checks++;
    if (upd !== 4'b0100) begin
      n_fail++; $display("FAIL commit_upd: got %b expected %b", upd, 4'b0100);
    end
    n_checks++;
    if (cregs !== 64'h0000_1234_0000_0000) begin
      n_fail++; $display("FAIL commit_bank: got %h expected %h", cregs, 64'h0000_1234_0000_0000);
    end
    n_checks++;
    if (ferr !== 1'b0) begin
      n_fail++; $display("FAIL commit_ferr: got %b expected %b", ferr, 1'b0);
    end
    @(negedge CLK);
    n_checks++;
    if (upd !== 4'b0000) begin
      n_fail++; $display("FAIL commit_pulse_len: got %b expected %b", upd, 4'b0000);
    end
  endtask

  task automatic test_bad_addr();
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h7E);
    send_byte(8'h04);
    n_checks++;
    if (ferr !== 1'b1) begin
      n_fail++; $display("FAIL badaddr_ferr: got %b expected %b", ferr, 1'b1);
    end
    n_checks++;
    if (upd !== 4'b0000) begin
      n_fail++; $display("FAIL badaddr_upd: got %b expected %b", upd, 4'b0000);
    end
    send_byte(8'hAA);
    n_checks++;
    if (ferr !== 1'b0) begin
      n_fail++; $display("FAIL badaddr_pulse_len: got %b expected %b", ferr, 1'b0);
    end
    send_byte(8'hBB);
    @(negedge CLK);
    n_checks++;
    if (cregs !== 64'h0000_1234_0000_0000) begin
      n_fail++; $display("FAIL badaddr_bank: got %h expected %h", cregs, 64'h0000_1234_0000_0000);
    end
  endtask

  task automatic test_resync();
    send_byte(8'h5A);
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h7E);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hFF);
`ifdef TRANSFER_CTRL_CHECKSUM_EN
    send_byte(8'hFE);
`endif
    n_checks++;
    if (upd !== 4'b0010) begin
      n_fail++; $display("FAIL resync_upd: got %b expected %b", upd, 4'b0010);
    end
    n_checks++;
    if (cregs !== 64'h0000_1234_00FF_0000) begin
      n_fail++; $display("FAIL resync_bank: got %h expected %h", cregs, 64'h0000_1234_00FF_0000);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h7E);
    send_byte(8'h00);
    send_byte(8'h12);
    // Reset coincides with what would be the final data byte.
    @(negedge CLK);
    RST     = 1'b1;
    byte_in = 8'h34;
    recv    = 1'b1;
    @(negedge CLK);
    RST  = 1'b0;
    recv = 1'b0;
    n_checks++;
    if (cregs !== 64'h0) begin
      n_fail++; $display("FAIL midreset_bank: got %h expected %h", cregs, 64'h0);
    end
    n_checks++;
    if (upd !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_upd: got %b expected %b", upd, 4'b0000);
    end
    @(negedge CLK);
    send_frame(8'h00, 8'h56, 8'h78);
    n_checks++;
    if (upd !== 4'b0001) begin
      n_fail++; $display("FAIL postreset_upd: got %b expected %b", upd, 4'b0001);
    end
    n_checks++;
    if (cregs !== 64'h0000_0000_0000_5678) begin
      n_fail++; $display("FAIL postreset_bank: got %h expected %h", cregs, 64'h0000_0000_0000_5678);
    end
  endtask

  task automatic test_hold_high();
    int early;
    early = 0;
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h7E);
    send_byte(8'h03);
    // Header value held high as data: must count as one byte only.
    @(negedge CLK);
    byte_in = 8'h5A;
    recv    = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (upd !== 4'b0000) early++;
    end
    recv = 1'b0;
    n_checks++;
    if (early !== 0) begin
      n_fail++; $display("FAIL hold_single_accept: got %0d early commits expected 0", early);
    end
    send_byte(8'h77);
`ifdef TRANSFER_CTRL_CHECKSUM_EN
    send_byte(8'h2E);
`endif
    n_checks++;
    if (upd !== 4'b1000) begin
      n_fail++; $display("FAIL hold_upd: got %b expected %b", upd, 4'b1000);
    end
    n_checks++;
    if (cregs !== 64'h5A77_0000_0000_5678) begin
      n_fail++; $display("FAIL hold_bank: got %h expected %h", cregs, 64'h5A77_0000_0000_5678);
    end
  endtask

  task automatic test_release_high();
    @(negedge CLK);
    RST     = 1'b1;
    byte_in = 8'h5A;
    recv    = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    recv = 1'b0;
    send_byte(8'hC3);
    send_byte(8'h7E);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
`ifdef TRANSFER_CTRL_CHECKSUM_EN
    send_byte(8'h32);
`endif
    n_checks++;
    if (upd !== 4'b0010) begin
      n_fail++; $display("FAIL release_upd: got %b expected %b", upd, 4'b0010);
    end
    n_checks++;
    if (cregs !== 64'h0000_0000_1122_0000) begin
      n_fail++; $display("FAIL release_bank: got %h expected %h", cregs, 64'h0000_0000_1122_0000);
    end
  endtask

  task automatic test_checksum();
`ifdef TRANSFER_CTRL_CHECKSUM_EN
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h7E);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h26);
    n_checks++;
    if (ferr !== 1'b1) begin
      n_fail++; $display("FAIL csum_bad_ferr: got %b expected %b", ferr, 1'b1);
    end
    n_checks++;
    if (upd !== 4'b0000) begin
      n_fail++; $display("FAIL csum_bad_upd: got %b expected %b", upd, 4'b0000);
    end
    n_checks++;
    if (cregs !== 64'h0000_0000_1122_0000) begin
      n_fail++; $display("FAIL csum_bad_bank: got %h expected %h", cregs, 64'h0000_0000_1122_0000);
    end
    send_byte(8'h5A);
    send_byte(8'hC3);
    send_byte(8'h7E);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h27);
    n_checks++;
    if (upd !== 4'b0010) begin
      n_fail++; $display("FAIL csum_good_upd: got %b expected %b", upd, 4'b0010);
    end
    n_checks++;
    if (cregs !== 64'h0000_0000_1234_0000) begin
      n_fail++; $display("FAIL csum_good_bank: got %h expected %h", cregs, 64'h0000_0000_1234_0000);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_commit();
    test_bad_addr();
    test_resync();
    test_reset_mid_frame();
    test_hold_high();
    test_release_high();
    test_checksum();
    repeat (2) @(negedge CLK);
    n_checks++;
    if (overlap !== 0) begin
      n_fail++; $display("FAIL err_upd_overlap: got %0d cycles expected 0", overlap);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
